// File: rtl/rf_rx_stream.sv
// rf_rx_stream: SPI read-snoop capture, byte packer and word FIFO.
// Optional drop_cnt/frag statistics are enabled by RF_RX_STREAM_STATS_EN.

module rf_rx_stream #(
    parameter int OUT_BYTES = 2,
    parameter int DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cs,
    input  logic                         sck,
    input  logic                         sdo,
    input  logic                         cap_en,
    input  logic                         flush,
    output logic [8*OUT_BYTES-1:0]       m_data,
    output logic [OUT_BYTES-1:0]         m_keep,
    output logic                         m_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         frag,
    output logic [7:0]                   drop_cnt
);

    localparam int DW = 8 * OUT_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    typedef struct packed {
        logic [DW-1:0]        data;
        logic [OUT_BYTES-1:0] keep;
        logic                 last;
    } ent_t;

    logic                 sck_q;
    logic                 cs_q;
    logic                 bit_ev;
    logic                 frame_start;
    logic                 frame_end;
    logic                 armed;
    logic [2:0]           bit_cnt;
    logic [6:0]           shreg;
    logic [7:0]           new_byte;
    logic [CW-1:0]        slot_cnt;
    logic                 last_slot;
    logic [DW-1:0]        pack_data;
    logic [DW-1:0]        ins_word;
    logic [OUT_BYTES-1:0] keep_part;
    logic                 pend_vld;
    logic [DW-1:0]        pend_data;
    logic                 push_vld;
    ent_t                 push_ent;

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    ent_t                 mem [DEPTH];
    ent_t                 head;
    logic                 pop;
    logic                 wr_en;
    logic                 drop;

    assign bit_ev      = sck & ~sck_q & ~cs;
    assign frame_start = ~cs & cs_q;
    assign frame_end   = cs & ~cs_q;
    assign new_byte    = {shreg, sdo};
    assign last_slot   = (slot_cnt == CW'(OUT_BYTES - 1));

    // Registered copies of the SPI strobes for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b0;
            cs_q  <= 1'b0;
        end else begin
            sck_q <= sck;
            cs_q  <= cs;
        end
    end

    // Word with the incoming byte dropped into its slot, plus partial keep.
    always_comb begin
        logic [OUT_BYTES-1:0] all_ones;
        all_ones  = '1;
        ins_word  = pack_data;
        ins_word[8*(OUT_BYTES-1-int'(slot_cnt)) +: 8] = new_byte;
        keep_part = ~(all_ones >> slot_cnt);
    end

    // Bit deserialiser, byte packer, pending word and frame delimiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            slot_cnt  <= '0;
            pack_data <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            push_vld  <= 1'b0;
            push_ent  <= '0;
        end else if (flush) begin
            armed     <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            slot_cnt  <= '0;
            pack_data <= '0;
            pend_vld  <= 1'b0;
            pend_data <= '0;
            push_vld  <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (frame_start) begin
                armed     <= cap_en;
                bit_cnt   <= {2'b00, bit_ev};
                shreg     <= {6'b0, sdo & bit_ev};
                slot_cnt  <= '0;
                pack_data <= '0;
                pend_vld  <= 1'b0;
            end else if (frame_end) begin
                if (armed) begin
                    if (pend_vld) begin
                        push_vld      <= 1'b1;
                        push_ent.data <= pend_data;
                        push_ent.keep <= '1;
                        push_ent.last <= 1'b1;
                    end else if (slot_cnt != '0) begin
                        push_vld      <= 1'b1;
                        push_ent.data <= pack_data;
                        push_ent.keep <= keep_part;
                        push_ent.last <= 1'b1;
                    end
                end
                armed     <= 1'b0;
                bit_cnt   <= '0;
                slot_cnt  <= '0;
                pack_data <= '0;
                pend_vld  <= 1'b0;
            end else if (bit_ev) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= new_byte[6:0];
                if (armed && bit_cnt == 3'd7) begin
                    if (pend_vld) begin
                        push_vld      <= 1'b1;
                        push_ent.data <= pend_data;
                        push_ent.keep <= '1;
                        push_ent.last <= 1'b0;
                    end
                    if (last_slot) begin
                        pend_vld  <= 1'b1;
                        pend_data <= ins_word;
                        slot_cnt  <= '0;
                        pack_data <= '0;
                    end else begin
                        pend_vld  <= 1'b0;
                        slot_cnt  <= slot_cnt + CW'(1);
                        pack_data <= ins_word;
                    end
                end
            end
        end
    end

    assign pop   = ~empty & m_ready;
    assign wr_en = push_vld & (~full | pop);
    assign drop  = push_vld & full & ~pop;

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                level <= level + LW'(1);
            else if (!wr_en && pop)
                level <= level - LW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO storage, kept reset-free so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem[wr_ptr] <= push_ent;
    end

    assign head    = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign m_valid = ~empty;
    assign m_data  = empty ? '0 : head.data;
    assign m_keep  = empty ? '0 : head.keep;
    assign m_last  = empty ? 1'b0 : head.last;

`ifdef RF_RX_STREAM_STATS_EN
    logic       frag_q;
    logic [7:0] drop_q;

    // Pulse when an armed frame closes on a partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frag_q <= 1'b0;
        else
            frag_q <= ~flush & frame_end & armed & (bit_cnt != 3'd0);
    end

    // Saturating count of words lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_q <= '0;
        else if (flush)
            drop_q <= '0;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign frag     = frag_q;
    assign drop_cnt = drop_q;
`else
    assign frag     = 1'b0;
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rf_rx_stream.sv
// tb_rf_rx_stream: directed frames against a queue model of the word stream.
// Statistic expectations follow RF_RX_STREAM_STATS_EN.

module tb_rf_rx_stream;

    localparam int OB    = 2;
    localparam int DW    = 8 * OB;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
`ifdef RF_RX_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cs;
    logic          sck;
    logic          sdo;
    logic          cap_en;
    logic          flush;
    logic [DW-1:0] m_data;
    logic [OB-1:0] m_keep;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          frag;
    logic [7:0]    drop_cnt;

    typedef struct {
        logic [DW-1:0] d;
        logic [OB-1:0] k;
        logic          l;
    } exp_t;

    exp_t model_q[$];
    exp_t tmp_q[$];
    int   checks      = 0;
    int   fails       = 0;
    int   model_drops = 0;
    int   frag_cnt    = 0;
    int   f0;

    rf_rx_stream #(.OUT_BYTES(OB), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .sdo(sdo),
        .cap_en(cap_en), .flush(flush),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .full(full), .empty(empty),
        .overflow(overflow), .frag(frag), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Words a frame must produce: bytes grouped MS-first, last word closes.
    task automatic gen(input logic [31:0] data, input int nbits);
        int   nb = nbits / 8;
        int   nw = (nb + OB - 1) / OB;
        exp_t e;
        tmp_q.delete();
        for (int w = 0; w < nw; w++) begin
            e.d = '0;
            e.k = '0;
            for (int s = 0; s < OB; s++) begin
                int idx = w * OB + s;
                if (idx < nb) begin
                    e.d[DW-1-8*s -: 8] = data[31-8*idx -: 8];
                    e.k[OB-1-s]        = 1'b1;
                end
            end
            e.l = (w == nw - 1);
            tmp_q.push_back(e);
        end
    endtask

    task automatic model_frame(input logic [31:0] data, input int nbits,
                               input bit cap, input bit nodrop);
        if (!cap) return;
        gen(data, nbits);
        foreach (tmp_q[i]) begin
            if (model_q.size() >= DEPTH && !nodrop)
                model_drops++;
            else
                model_q.push_back(tmp_q[i]);
        end
    endtask

    task automatic frame_begin(input bit cap);
        tick(1);
        cs     = 1'b0;
        cap_en = cap;
        tick(1);
        cap_en = 1'b0;
        tick(1);
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sdo = data[31-i];
            sck = 1'b0;
            tick(2);
            sck = 1'b1;
            tick(2);
        end
        sck = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits,
                              input bit cap);
        model_frame(data, nbits, cap, 1'b0);
        frame_begin(cap);
        send_bits(data, nbits);
        cs  = 1'b1;
        sdo = 1'b0;
        tick(4);
    endtask

    task automatic drain();
        m_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (empty && model_q.size() == 0) break;
        end
        chk("drain_empty", empty, 1);
        chk("drain_model_left", model_q.size(), 0);
        m_ready = 1'b0;
    endtask

    // Stream checker: head word against the model front every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("empty_vs_level", empty, level == 0);
            chk("full_vs_level", full, level == DEPTH);
            chk("valid_vs_empty", m_valid, !empty);
            if (m_valid) begin
                if (model_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none",
                             m_data);
                end else begin
                    chk("word_data", m_data, model_q[0].d);
                    chk("word_keep", m_keep, model_q[0].k);
                    chk("word_last", m_last, model_q[0].l);
                    if (m_ready) void'(model_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && frag) frag_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        cs      = 1'b1;
        sck     = 1'b0;
        sdo     = 1'b0;
        cap_en  = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        #12;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_keep", m_keep, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frag", frag, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        gen(32'hA53C7E00, 24);
        chk("model_a5_count", tmp_q.size(), 2);
        chk("model_a5_w0", {tmp_q[0].d, tmp_q[0].k, tmp_q[0].l},
            {16'hA53C, 2'b11, 1'b0});
        chk("model_a5_w1", {tmp_q[1].d, tmp_q[1].k, tmp_q[1].l},
            {16'h7E00, 2'b10, 1'b1});
        gen(32'hC3A00000, 11);
        chk("model_c3_count", tmp_q.size(), 1);
        chk("model_c3_w0", {tmp_q[0].d, tmp_q[0].k, tmp_q[0].l},
            {16'hC300, 2'b10, 1'b1});

        send_frame(32'hA53C7E00, 24, 1'b1);
        tick(2);
        chk("t1_level", level, 2);
        chk("t1_head_data", m_data, 16'hA53C);
        chk("t1_head_keep", m_keep, 2'b11);
        chk("t1_head_last", m_last, 0);
        drain();

        model_frame(32'h12345678, 32, 1'b1, 1'b0);
        frame_begin(1'b1);
        send_bits(32'h12345678, 32);
        tick(4);
        chk("t2_level_before_end", level, 1);
        chk("t2_head_data", m_data, 16'h1234);
        chk("t2_head_last", m_last, 0);
        cs = 1'b1;
        tick(4);
        chk("t2_level_after_end", level, 2);
        drain();

        f0 = frag_cnt;
        model_frame(32'hC3A00000, 11, 1'b1, 1'b0);
        frame_begin(1'b1);
        send_bits(32'hC3A00000, 11);
        chk("t3_valid_before_end", m_valid, 0);
        cs = 1'b1;
        tick(1);
        chk("t3_valid_cycle1", m_valid, 0);
        chk("t3_frag_cycle1", frag, STATS);
        tick(1);
        chk("t3_valid_cycle2", m_valid, 1);
        chk("t3_frag_cycle2", frag, 0);
        chk("t3_data", m_data, 16'hC300);
        chk("t3_keep", m_keep, 2'b10);
        chk("t3_last", m_last, 1);
        tick(2);
        chk("t3_frag_pulses", frag_cnt - f0, STATS ? 1 : 0);
        drain();

        f0 = frag_cnt;
        send_frame(32'hC3A00000, 11, 1'b0);
        chk("t4_noncap_level", level, 0);
        chk("t4_noncap_frag", frag_cnt - f0, 0);

        f0 = frag_cnt;
        frame_begin(1'b1);
        send_bits(32'hF8000000, 5);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_level", level, 0);
        tick(2);
        rst_n = 1'b1;
        send_bits(32'hAB000000, 8);
        cs = 1'b1;
        tick(4);
        chk("t5_abandoned_level", level, 0);
        chk("t5_abandoned_frag", frag_cnt - f0, 0);
        send_frame(32'h99110000, 16, 1'b1);
        chk("t5_level", level, 1);
        chk("t5_data", m_data, 16'h9911);
        chk("t5_last", m_last, 1);
        drain();

        for (int i = 0; i < 6; i++)
            send_frame({8'(i * 16 + 1), 8'(i * 16 + 2), 16'h0}, 16, 1'b1);
        tick(2);
        chk("t6_model_drops", model_drops, 2);
        chk("t6_level", level, 4);
        chk("t6_full", full, 1);
        chk("t6_overflow", overflow, 1);
        chk("t6_drop_cnt", drop_cnt, STATS ? 2 : 0);
        drain();
        chk("t6_overflow_sticky", overflow, 1);

        for (int i = 0; i < 3; i++)
            send_frame({8'(8'hA0 + i), 8'h55, 16'h0}, 16, 1'b1);
        tick(2);
        chk("t7_level_before_flush", level, 3);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        model_q.delete();
        chk("t7_empty", empty, 1);
        chk("t7_level", level, 0);
        chk("t7_valid", m_valid, 0);
        chk("t7_overflow", overflow, 0);
        chk("t7_drop_cnt", drop_cnt, 0);

        for (int i = 0; i < 4; i++)
            send_frame({8'h3C, 8'(8'hC0 + i), 16'h0}, 16, 1'b1);
        tick(2);
        chk("t8_full_before", full, 1);
        model_frame(32'hBEEF0000, 16, 1'b1, 1'b1);
        frame_begin(1'b1);
        send_bits(32'hBEEF0000, 16);
        cs = 1'b1;
        tick(1);
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        chk("t8_level", level, 4);
        chk("t8_full", full, 1);
        chk("t8_overflow", overflow, 0);
        chk("t8_drop_cnt", drop_cnt, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
